coin_credit_collector: RTL

Front-end stage of the vending machine, upstream of the top-level purchase logic. Accepts coin insertions, accumulates customer credit in a 7-bit register, captures the customer's item selection, and presents a single purchase request (money, type, amount) through a valid/ready handshake. Cancellation and an inactivity timeout return the collected credit through a one-cycle refund strobe.

---
 rtl/coin_credit_collector_pkg.sv | 34 +++
 rtl/coin_credit_collector_inactivity_timer.sv | 41 ++++
 rtl/coin_credit_collector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/coin_credit_collector_pkg.sv
// Shared vending-machine types: FSM states, coin codes and coin values.
// Pure declarations, no logic.
// Widths here are reused by the collector top level.
package vm_pkg;

  localparam int MONEY_W  = 7;
  localparam int TYPE_W   = 3;
  localparam int AMOUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQUEST = 2'd2,
    ST_REFUND  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_e;

  // Face value of a coin code.
  function automatic logic [3:0] coin_value(input coin_e code);
    case (code)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/coin_credit_collector_inactivity_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear.
// expire is high on the TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle.
// No handshake; clear has priority over enable.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int                 LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [TIMER_W-1:0] LAST   = LAST_I[TIMER_W-1:0];

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/coin_credit_collector.sv
// Coin collector: accumulates credit, latches a selection, issues one purchase request.
// Request appears one cycle after an accepted selection; refunds are one-cycle strobes.
// req_valid holds with stable payload until req_ready; coins are rejected while not collecting.
module coin_credit_collector
  import vm_pkg::*;
#(
  parameter int MAX_CREDIT     = 127,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                sel_valid,
  input  logic [TYPE_W-1:0]   sel_type,
  input  logic [AMOUNT_W-1:0] sel_amount,
  input  logic                cancel,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [MONEY_W-1:0]  req_money,
  output logic [TYPE_W-1:0]   req_type,
  output logic [AMOUNT_W-1:0] req_amount,
  output logic                coin_reject,
  output logic                refund_valid,
  output logic [MONEY_W-1:0]  refund_amount,
  output logic                busy
);

  localparam logic [MONEY_W:0] MAX_SUM = MAX_CREDIT[MONEY_W:0];

  state_e                state_q, state_d;
  logic [MONEY_W-1:0]    credit_q, credit_d;
  logic [TYPE_W-1:0]     type_q, type_d;
  logic [AMOUNT_W-1:0]   amount_q, amount_d;
  logic                  coin_reject_q, coin_reject_d;

  logic [MONEY_W:0]      coin_sum;
  logic                  coin_fits;
  logic                  sel_take;
  logic                  coin_accept;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_expire;

  // Sum is one bit wider than credit so an overflowing coin never wraps.
  assign coin_sum  = {1'b0, credit_q} + {4'b0000, coin_value(coin_e'(coin_code))};
  assign coin_fits = (coin_sum <= MAX_SUM);
  assign sel_take  = sel_valid && (sel_amount != '0);

  // A coin is taken only while collecting and only if nothing higher-priority wins the cycle.
  always_comb begin
    coin_accept = 1'b0;
    case (state_q)
      ST_IDLE:    coin_accept = coin_valid && coin_fits;
      ST_COLLECT: coin_accept = coin_valid && coin_fits && !cancel && !sel_take;
      default:    coin_accept = 1'b0;
    endcase
  end

  // Timer runs only in COLLECT and restarts on every accepted coin.
  assign timer_enable = (state_q == ST_COLLECT);
  assign timer_clear  = coin_accept || (state_q != ST_COLLECT);

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: cancel beats selection beats timeout within COLLECT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_accept) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (cancel)            state_d = ST_REFUND;
        else if (sel_take)     state_d = ST_REQUEST;
        else if (timer_expire) state_d = ST_REFUND;
      end
      ST_REQUEST: begin
        if (req_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    req_valid    = 1'b0;
    refund_valid = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE:    busy         = 1'b0;
      ST_REQUEST: req_valid    = 1'b1;
      ST_REFUND:  refund_valid = 1'b1;
      default:    busy         = 1'b1;
    endcase
  end

  // Datapath next values: credit, selection latches and the reject pulse.
  always_comb begin
    credit_d      = credit_q;
    type_d        = type_q;
    amount_d      = amount_q;
    coin_reject_d = coin_valid && !coin_accept;
    case (state_q)
      ST_IDLE: begin
        if (coin_accept) credit_d = coin_sum[MONEY_W-1:0];
      end
      ST_COLLECT: begin
        if (coin_accept) credit_d = coin_sum[MONEY_W-1:0];
        if (!cancel && sel_take) begin
          type_d   = sel_type;
          amount_d = sel_amount;
        end
      end
      ST_REQUEST: begin
        if (req_ready) credit_d = '0;
      end
      default: credit_d = '0;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q      <= '0;
      type_q        <= '0;
      amount_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      credit_q      <= credit_d;
      type_q        <= type_d;
      amount_q      <= amount_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign req_money     = credit_q;
  assign req_type      = type_q;
  assign req_amount    = amount_q;
  assign refund_amount = credit_q;
  assign coin_reject   = coin_reject_q;

endmodule
